// File: rtl/count_sequencer_pkg.sv
// Shared definitions for the display-counter run controller: state encodings,
// rate-select codes and counting modes.
package count_sequencer_pkg;

  localparam int unsigned COUNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] RATE_EVERY = 2'b00;
  localparam logic [1:0] RATE_DIV1  = 2'b01;
  localparam logic [1:0] RATE_DIV2  = 2'b10;
  localparam logic [1:0] RATE_DIV3  = 2'b11;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/count_sequencer_rate_divider.sv
// Reloadable down-counter; tick flags div==0. load forces a value, hold freezes,
// otherwise it counts down and reloads from zero.
module rate_divider #(
  parameter int unsigned DIV_W = 28
) (
  input  logic             clk,
  input  logic             clear_b,
  input  logic             load,
  input  logic             hold,
  input  logic [DIV_W-1:0] reload,
  output logic             tick
);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      div <= '0;
    end else if (load) begin
      div <= reload;
    end else if (!hold) begin
      div <= (div == '0) ? reload : div - DIV_W'(1);
    end
  end

  assign tick = (div == '0);

endmodule

// File: rtl/count_sequencer.sv
// Run controller for the 8-bit display counter: IDLE/RUN/PAUSE/DONE sequencing,
// tick-rate selection and wrap or one-shot counting against a live limit.
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int unsigned DIV_W = 28,
  parameter int unsigned DIV1  = 49_999_999,
  parameter int unsigned DIV2  = 99_999_999,
  parameter int unsigned DIV3  = 199_999_999
) (
  input  logic               clk,
  input  logic               clear_b,
  input  logic               start,
  input  logic               stop,
  input  logic               clr,
  input  logic               mode,
  input  logic [1:0]         rate_sel,
  input  logic [COUNT_W-1:0] limit,
  output logic [COUNT_W-1:0] count,
  output logic               tick,
  output logic               running,
  output logic               done
);

  state_e             state, state_nxt;
  logic [COUNT_W-1:0] count_nxt, count_inc;
  logic [DIV_W-1:0]   rate_reload, div_reload;
  logic               div_load, div_hold, div_zero;

  // Reload value selected live; the divider only samples it on a reload.
  always_comb begin
    rate_reload = '0;
    case (rate_sel)
      RATE_EVERY: rate_reload = '0;
      RATE_DIV1:  rate_reload = DIV_W'(DIV1);
      RATE_DIV2:  rate_reload = DIV_W'(DIV2);
      RATE_DIV3:  rate_reload = DIV_W'(DIV3);
      default:    rate_reload = '0;
    endcase
  end

  rate_divider #(.DIV_W(DIV_W)) u_div (
    .clk     (clk),
    .clear_b (clear_b),
    .load    (div_load),
    .hold    (div_hold),
    .reload  (div_reload),
    .tick    (div_zero)
  );

  assign count_inc = count + COUNT_W'(1);

  // Next state, count and divider control; clr > stop > start.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    div_load   = 1'b0;
    div_hold   = 1'b1;
    div_reload = rate_reload;

    if (clr) begin
      state_nxt  = ST_IDLE;
      count_nxt  = '0;
      div_load   = 1'b1;
      div_reload = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          count_nxt = '0;
          div_load  = 1'b1;
          if (start && !stop) begin
            state_nxt = ST_RUN;
          end else begin
            div_reload = '0;
          end
        end
        ST_RUN: begin
          // A tick cycle always reloads the divider, even when pausing.
          div_hold = stop && !div_zero;
          if (stop) begin
            state_nxt = ST_PAUSE;
          end
          if (div_zero) begin
            if (mode == MODE_WRAP) begin
              count_nxt = (count == limit) ? '0 : count_inc;
            end else begin
              count_nxt = count_inc;
              if (count_inc == limit) begin
                state_nxt = ST_DONE;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (start && !stop) begin
            state_nxt = ST_RUN;
          end
        end
        ST_DONE: begin
          if (start && !stop) begin
            state_nxt = ST_RUN;
            count_nxt = '0;
            div_load  = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Moore decode from registered state and divider value.
  assign running = (state == ST_RUN);
  assign done    = (state == ST_DONE);
  assign tick    = running && div_zero;

endmodule
